// File: rtl/sync_fifo_param.sv
// -----------------------------------------------------------------------------
// sync_fifo_param
//   Single-clock FIFO with parametrised width/depth, occupancy count,
//   programmable almost-full / almost-empty thresholds and sticky
//   overflow / underflow flags. The read side runs either in standard mode
//   (registered read, one cycle of latency) or in first-word-fall-through
//   mode (head word pre-loaded into the output register).
//
// Handshake semantics:
//   A write is accepted on a rising CLK edge when wr_en && !full.
//   A read is accepted on a rising CLK edge when rd_en && !empty.
//   In FWFT mode, rd_en acknowledges the word currently shown on dout
//   (valid == 1). A rejected request changes no data; it only sets the
//   matching sticky flag.
//
// Ports:
//   CLK          clock, rising edge
//   RST          asynchronous active-high reset
//   srst         synchronous active-high clear (same end state as RST)
//   din          write data
//   wr_en        write request
//   rd_en        read request / FWFT acknowledge
//   dout         registered read data
//   valid        dout holds a valid word
//   full         count == DEPTH
//   empty        standard: count == 0; FWFT: !valid
//   almost_full  count >= AF_TH
//   almost_empty count <= AE_TH
//   count        words held (FWFT: includes the output register)
//   overflow     sticky: write attempted while full
//   underflow    sticky: read attempted while empty
// -----------------------------------------------------------------------------
module sync_fifo_param #(
   parameter int DATA_W     = 4,
   parameter int DEPTH_LOG2 = 4,
   parameter int FWFT       = 0,
   parameter int AF_TH      = (2**DEPTH_LOG2) - 2,
   parameter int AE_TH      = 1
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  srst,
   input  logic [DATA_W-1:0]     din,
   input  logic                  wr_en,
   input  logic                  rd_en,
   output logic [DATA_W-1:0]     dout,
   output logic                  valid,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int DEPTH = 2**DEPTH_LOG2;
   localparam int CW    = DEPTH_LOG2 + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] AF_C    = CW'(AF_TH);
   localparam logic [CW-1:0] AE_C    = CW'(AE_TH);
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

   logic [DATA_W-1:0]     mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2-1:0] rd_ptr;
   logic [CW-1:0]         mem_cnt;      // words held in the memory array only
   logic [CW-1:0]         mem_cnt_nxt;
   logic [CW-1:0]         count_nxt;
   logic                  wr_acc;
   logic                  rd_acc;
   logic                  pop;          // memory head moves to dout this edge
   logic                  valid_nxt;
   logic                  ovf_evt;
   logic                  udf_evt;

   always_comb begin
      wr_acc    = wr_en && !full;
      ovf_evt   = wr_en && full;
      rd_acc    = 1'b0;
      udf_evt   = 1'b0;
      pop       = 1'b0;
      valid_nxt = 1'b0;
      if (FWFT != 0) begin
         // The output register refills whenever it is empty or being
         // acknowledged, as long as the memory has a word to give.
         rd_acc    = rd_en && valid;
         udf_evt   = rd_en && !valid;
         pop       = (!valid || rd_acc) && (mem_cnt != '0);
         valid_nxt = pop || (valid && !rd_acc);
      end else begin
         rd_acc    = rd_en && !empty;
         udf_evt   = rd_en && empty;
         pop       = rd_acc;
         valid_nxt = rd_acc;
      end
      mem_cnt_nxt = mem_cnt + CW'(wr_acc) - CW'(pop);
      // In FWFT mode the output register is part of the occupancy.
      count_nxt   = (FWFT != 0) ? (mem_cnt_nxt + CW'(valid_nxt)) : mem_cnt_nxt;
   end

   // Storage array: no reset, contents are don't-care after a clear.
   always_ff @(posedge CLK) begin
      if (wr_acc && !srst) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         mem_cnt      <= '0;
         count        <= '0;
         dout         <= '0;
         valid        <= 1'b0;
         full         <= 1'b0;
         empty        <= 1'b1;
         almost_full  <= 1'b0;
         almost_empty <= 1'b1;
         overflow     <= 1'b0;
         underflow    <= 1'b0;
      end else if (srst) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         mem_cnt      <= '0;
         count        <= '0;
         dout         <= '0;
         valid        <= 1'b0;
         full         <= 1'b0;
         empty        <= 1'b1;
         almost_full  <= 1'b0;
         almost_empty <= 1'b1;
         overflow     <= 1'b0;
         underflow    <= 1'b0;
      end else begin
         if (wr_acc) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
            dout   <= mem[rd_ptr];
         end
         mem_cnt      <= mem_cnt_nxt;
         count        <= count_nxt;
         valid        <= valid_nxt;
         full         <= (count_nxt == DEPTH_C);
         empty        <= (FWFT != 0) ? !valid_nxt : (count_nxt == '0);
         almost_full  <= (count_nxt >= AF_C);
         almost_empty <= (count_nxt <= AE_C);
         if (ovf_evt) begin
            overflow <= 1'b1;
         end
         if (udf_evt) begin
            underflow <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_sync_fifo_param.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_param
//   Bench for sync_fifo_param: one standard-mode instance and one FWFT
//   instance sharing the same clock, resets and request inputs.
// -----------------------------------------------------------------------------
module tb_sync_fifo_param;

   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic       srst = 1'b0;
   logic [3:0] din = '0;
   logic       wr_en = 1'b0;
   logic       rd_en = 1'b0;

   logic [3:0] s_dout, f_dout;
   logic       s_valid, s_full, s_empty, s_af, s_ae, s_ovf, s_udf;
   logic       f_valid, f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
   logic [4:0] s_count, f_count;

   wire [6:0] s_stat = {s_valid, s_full, s_empty, s_af, s_ae, s_ovf, s_udf};
   wire [6:0] f_stat = {f_valid, f_full, f_empty, f_af, f_ae, f_ovf, f_udf};
   localparam logic [6:0] RST_STAT = 7'b0010100;

   sync_fifo_param #(.DATA_W(4), .DEPTH_LOG2(4), .FWFT(0)) u_std (
      .CLK(CLK), .RST(RST), .srst(srst), .din(din), .wr_en(wr_en), .rd_en(rd_en),
      .dout(s_dout), .valid(s_valid), .full(s_full), .empty(s_empty),
      .almost_full(s_af), .almost_empty(s_ae), .count(s_count),
      .overflow(s_ovf), .underflow(s_udf)
   );

   sync_fifo_param #(.DATA_W(4), .DEPTH_LOG2(4), .FWFT(1)) u_fw (
      .CLK(CLK), .RST(RST), .srst(srst), .din(din), .wr_en(wr_en), .rd_en(rd_en),
      .dout(f_dout), .valid(f_valid), .full(f_full), .empty(f_empty),
      .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
      .overflow(f_ovf), .underflow(f_udf)
   );

   // ---------------- clock / reset ----------------
   always #5 CLK = ~CLK;

   // ---------------- scoreboard / standard-mode reference ----------------
   int         n_checks = 0;
   int         n_errors = 0;
   logic [3:0] exp_q[$];
   int         mdl_cnt = 0;
   logic       m_ovf = 1'b0;
   logic       m_udf = 1'b0;
   logic       m_rd  = 1'b0;
   logic [3:0] exp_d;

   task automatic model_clear();
      mdl_cnt = 0;
      m_ovf   = 1'b0;
      m_udf   = 1'b0;
      m_rd    = 1'b0;
      exp_q.delete();
   endtask

   // Raw driver: apply inputs for one edge, return #1 after that edge.
   task automatic tick(input logic w, input logic r, input logic [3:0] d);
      wr_en = w;
      rd_en = r;
      din   = d;
      @(posedge CLK);
      #1;
      wr_en = 1'b0;
      rd_en = 1'b0;
   endtask

   // Driver with the standard-mode reference: accepted writes are pushed
   // to exp_q; m_rd tells the caller a word is due on dout after the edge.
   task automatic drive(input logic w, input logic r, input logic [3:0] d);
      logic wa, ra;
      wa = w && (mdl_cnt < 16);
      ra = r && (mdl_cnt > 0);
      if (w && !wa) m_ovf = 1'b1;
      if (r && !ra) m_udf = 1'b1;
      if (wa) exp_q.push_back(d);
      m_rd = ra;
      mdl_cnt = mdl_cnt + int'(wa) - int'(ra);
      tick(w, r, d);
   endtask

   task automatic do_reset();
      RST = 1'b1;
      srst = 1'b0;
      #3;
      RST = 1'b0;
      @(posedge CLK);
      #1;
      model_clear();
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      do_reset();
      n_checks++;
      if (s_stat !== RST_STAT) begin n_errors++; $display("FAIL reset_std_flags: got %b exp %b", s_stat, RST_STAT); end
      n_checks++;
      if (s_count !== 5'd0 || s_dout !== 4'd0) begin n_errors++; $display("FAIL reset_std_count_dout: got %0d/%0h exp 0/0", s_count, s_dout); end
      n_checks++;
      if (f_stat !== RST_STAT || f_count !== 5'd0) begin n_errors++; $display("FAIL reset_fwft: got %b/%0d exp %b/0", f_stat, f_count, RST_STAT); end
   endtask

   task automatic test_basic();
      logic [3:0] want [2];
      want[0] = 4'h9;
      want[1] = 4'hE;
      do_reset();
      drive(1'b1, 1'b0, 4'b1001);
      n_checks++;
      if (s_count !== 5'd1) begin n_errors++; $display("FAIL basic_count_w1: got %0d exp 1", s_count); end
      drive(1'b1, 1'b0, 4'b1110);
      n_checks++;
      if (s_count !== 5'd2) begin n_errors++; $display("FAIL basic_count_w2: got %0d exp 2", s_count); end
      repeat (6) drive(1'b0, 1'b0, 4'h0);
      for (int i = 0; i < 2; i++) begin
         drive(1'b0, 1'b1, 4'h0);
         exp_d = exp_q.pop_front();
         n_checks++;
         if (s_valid !== 1'b1 || s_dout !== want[i] || exp_d !== want[i]) begin
            n_errors++; $display("FAIL basic_read%0d: got v=%b d=%0h exp v=1 d=%0h", i, s_valid, s_dout, want[i]);
         end
         n_checks++;
         if (s_count !== 5'(1 - i)) begin n_errors++; $display("FAIL basic_count_r%0d: got %0d exp %0d", i, s_count, 1 - i); end
      end
      n_checks++;
      if (s_empty !== 1'b1 || s_ovf !== 1'b0 || s_udf !== 1'b0) begin
         n_errors++; $display("FAIL basic_flags: got e=%b o=%b u=%b exp 1/0/0", s_empty, s_ovf, s_udf);
      end
      drive(1'b0, 1'b0, 4'h0);
      n_checks++;
      if (s_valid !== 1'b0 || s_dout !== 4'hE) begin n_errors++; $display("FAIL basic_hold: got v=%b d=%0h exp v=0 d=e", s_valid, s_dout); end
   endtask

   task automatic test_fill_overflow();
      do_reset();
      for (int i = 0; i < 17; i++) begin
         drive(1'b1, 1'b0, 4'(i));
         n_checks++;
         if (s_count !== 5'(mdl_cnt) || s_full !== (mdl_cnt == 16) || s_af !== (mdl_cnt >= 14) || s_ovf !== m_ovf) begin
            n_errors++;
            $display("FAIL fill_w%0d: got c=%0d f=%b af=%b o=%b exp c=%0d f=%b af=%b o=%b", i, s_count, s_full, s_af, s_ovf,
                     mdl_cnt, (mdl_cnt == 16), (mdl_cnt >= 14), m_ovf);
         end
      end
      n_checks++;
      if (s_ovf !== 1'b1 || s_count !== 5'd16) begin n_errors++; $display("FAIL fill_overflow: got o=%b c=%0d exp o=1 c=16", s_ovf, s_count); end
      for (int i = 0; i < 17; i++) begin
         drive(1'b0, 1'b1, 4'h0);
         n_checks++;
         if (s_valid !== m_rd) begin n_errors++; $display("FAIL drain_valid%0d: got %b exp %b", i, s_valid, m_rd); end
         if (m_rd) begin
            exp_d = exp_q.pop_front();
            n_checks++;
            if (s_dout !== exp_d) begin n_errors++; $display("FAIL drain_data%0d: got %0h exp %0h", i, s_dout, exp_d); end
         end
         n_checks++;
         if (s_count !== 5'(mdl_cnt) || s_empty !== (mdl_cnt == 0) || s_ae !== (mdl_cnt <= 1) || s_udf !== m_udf) begin
            n_errors++;
            $display("FAIL drain_flags%0d: got c=%0d e=%b ae=%b u=%b exp c=%0d e=%b ae=%b u=%b", i, s_count, s_empty, s_ae, s_udf,
                     mdl_cnt, (mdl_cnt == 0), (mdl_cnt <= 1), m_udf);
         end
      end
      n_checks++;
      if (s_udf !== 1'b1 || s_dout !== 4'hF) begin n_errors++; $display("FAIL underflow_hold: got u=%b d=%0h exp u=1 d=f", s_udf, s_dout); end
   endtask

   task automatic test_back_to_back_wrap();
      do_reset();
      for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 4'(i));
      for (int i = 0; i < 30; i++) begin
         if (i < 20) drive(1'b1, 1'b1, 4'(i + 10));
         else        drive(1'b0, 1'b1, 4'h0);
         n_checks++;
         if (s_valid !== 1'b1) begin n_errors++; $display("FAIL wrap_valid%0d: got %b exp 1", i, s_valid); end
         exp_d = exp_q.pop_front();
         n_checks++;
         if (s_dout !== exp_d) begin n_errors++; $display("FAIL wrap_data%0d: got %0h exp %0h", i, s_dout, exp_d); end
         n_checks++;
         if (s_count !== 5'(mdl_cnt)) begin n_errors++; $display("FAIL wrap_count%0d: got %0d exp %0d", i, s_count, mdl_cnt); end
      end
      n_checks++;
      if (s_ovf !== 1'b0 || s_udf !== 1'b0) begin n_errors++; $display("FAIL wrap_sticky: got o=%b u=%b exp 0/0", s_ovf, s_udf); end
   endtask

   task automatic test_full_simul();
      do_reset();
      for (int i = 0; i < 16; i++) drive(1'b1, 1'b0, 4'(15 - i));
      drive(1'b1, 1'b1, 4'h7);
      exp_d = exp_q.pop_front();
      n_checks++;
      if (s_count !== 5'd15 || s_ovf !== 1'b1 || s_full !== 1'b0) begin
         n_errors++; $display("FAIL full_simul_flags: got c=%0d o=%b f=%b exp c=15 o=1 f=0", s_count, s_ovf, s_full);
      end
      n_checks++;
      if (s_valid !== 1'b1 || s_dout !== 4'hF || exp_d !== 4'hF) begin n_errors++; $display("FAIL full_simul_data: got v=%b d=%0h exp v=1 d=f", s_valid, s_dout); end
      for (int i = 0; i < 15; i++) begin
         drive(1'b0, 1'b1, 4'h0);
         exp_d = exp_q.pop_front();
         n_checks++;
         if (s_dout !== exp_d) begin n_errors++; $display("FAIL full_simul_drain%0d: got %0h exp %0h", i, s_dout, exp_d); end
      end
   endtask

   task automatic test_fwft();
      do_reset();
      tick(1'b1, 1'b0, 4'hA);
      exp_q.push_back(4'hA);
      n_checks++;
      if (f_valid !== 1'b0 || f_empty !== 1'b1 || f_count !== 5'd1) begin
         n_errors++; $display("FAIL fwft_edge_n: got v=%b e=%b c=%0d exp v=0 e=1 c=1", f_valid, f_empty, f_count);
      end
      tick(1'b0, 1'b0, 4'h0);
      n_checks++;
      if (f_valid !== 1'b1 || f_dout !== 4'hA || f_empty !== 1'b0 || f_count !== 5'd1) begin
         n_errors++; $display("FAIL fwft_edge_n1: got v=%b d=%0h e=%b c=%0d exp v=1 d=a e=0 c=1", f_valid, f_dout, f_empty, f_count);
      end
      tick(1'b1, 1'b0, 4'hB);
      exp_q.push_back(4'hB);
      tick(1'b1, 1'b0, 4'hC);
      exp_q.push_back(4'hC);
      n_checks++;
      if (f_count !== 5'd3) begin n_errors++; $display("FAIL fwft_count3: got %0d exp 3", f_count); end
      for (int i = 0; i < 3; i++) begin
         exp_d = exp_q.pop_front();
         n_checks++;
         if (f_valid !== 1'b1 || f_dout !== exp_d) begin n_errors++; $display("FAIL fwft_data%0d: got v=%b d=%0h exp v=1 d=%0h", i, f_valid, f_dout, exp_d); end
         tick(1'b0, 1'b1, 4'h0);
         n_checks++;
         if (f_count !== 5'(2 - i)) begin n_errors++; $display("FAIL fwft_count_r%0d: got %0d exp %0d", i, f_count, 2 - i); end
      end
      n_checks++;
      if (f_valid !== 1'b0 || f_empty !== 1'b1 || f_udf !== 1'b0) begin
         n_errors++; $display("FAIL fwft_drained: got v=%b e=%b u=%b exp 0/1/0", f_valid, f_empty, f_udf);
      end
      tick(1'b0, 1'b1, 4'h0);
      n_checks++;
      if (f_udf !== 1'b1) begin n_errors++; $display("FAIL fwft_underflow: got %b exp 1", f_udf); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 4'(i + 3));
      drive(1'b0, 1'b1, 4'h0);
      n_checks++;
      if (s_count !== 5'd7 || s_dout !== 4'h3) begin n_errors++; $display("FAIL mid_pre: got c=%0d d=%0h exp c=7 d=3", s_count, s_dout); end
      #2;
      RST = 1'b1;
      #1;
      n_checks++;
      if (s_stat !== RST_STAT || s_count !== 5'd0 || s_dout !== 4'h0) begin
         n_errors++; $display("FAIL mid_async: got %b/%0d/%0h exp %b/0/0", s_stat, s_count, s_dout, RST_STAT);
      end
      n_checks++;
      if (f_stat !== RST_STAT || f_count !== 5'd0) begin n_errors++; $display("FAIL mid_async_fwft: got %b/%0d exp %b/0", f_stat, f_count, RST_STAT); end
      #1;
      RST = 1'b0;
      model_clear();
      @(posedge CLK);
      #1;
      for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 4'(i + 8));
      drive(1'b0, 1'b1, 4'h0);
      n_checks++;
      if (s_count !== 5'd7 || s_dout !== 4'h8) begin n_errors++; $display("FAIL mid_refill: got c=%0d d=%0h exp c=7 d=8", s_count, s_dout); end
      srst = 1'b1;
      #1;
      n_checks++;
      if (s_count !== 5'd7) begin n_errors++; $display("FAIL srst_not_async: got %0d exp 7", s_count); end
      tick(1'b0, 1'b0, 4'h0);
      srst = 1'b0;
      model_clear();
      n_checks++;
      if (s_stat !== RST_STAT || s_count !== 5'd0 || s_dout !== 4'h0) begin
         n_errors++; $display("FAIL srst_state: got %b/%0d/%0h exp %b/0/0", s_stat, s_count, s_dout, RST_STAT);
      end
      drive(1'b1, 1'b0, 4'h5);
      drive(1'b0, 1'b1, 4'h0);
      exp_d = exp_q.pop_front();
      n_checks++;
      if (s_valid !== 1'b1 || s_dout !== exp_d || s_count !== 5'd0) begin
         n_errors++; $display("FAIL post_srst_data: got v=%b d=%0h c=%0d exp v=1 d=%0h c=0", s_valid, s_dout, s_count, exp_d);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_fill_overflow();
      test_back_to_back_wrap();
      test_full_simul();
      test_fwft();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
